// File: rtl/data_unpacker_pkg.sv
// Shared mode encoding for the trace-vector packer/unpacker pair.
// Both ends decode the same firmware byte into a chunk length, cast flag and drop flag.
package data_unpacker_pkg;

  localparam logic [7:0] MODE_N      = 8'd0;
  localparam logic [7:0] MODE_M      = 8'd1;
  localparam logic [7:0] MODE_1      = 8'd2;
  localparam logic [7:0] MODE_N_CAST = 8'd3;
  localparam logic [7:0] MODE_M_CAST = 8'd4;
  localparam logic [7:0] MODE_1_CAST = 8'd5;

  typedef enum logic [1:0] {
    LenN,
    LenM,
    Len1
  } len_e;

  typedef struct packed {
    len_e len;
    logic cast;
    logic drop;
  } mode_dec_t;

  function automatic mode_dec_t decode_mode(input logic [7:0] mode);
    mode_dec_t dec;
    dec.len  = LenN;
    dec.cast = 1'b0;
    dec.drop = 1'b0;
    case (mode)
      MODE_N:      dec.len = LenN;
      MODE_M:      dec.len = LenM;
      MODE_1:      dec.len = Len1;
      MODE_N_CAST: begin dec.len = LenN; dec.cast = 1'b1; end
      MODE_M_CAST: begin dec.len = LenM; dec.cast = 1'b1; end
      MODE_1_CAST: begin dec.len = Len1; dec.cast = 1'b1; end
      default:     dec.drop = 1'b1;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/data_unpacker_if.sv
// Packed-vector input and chunk output handshakes of the unpacker.
interface data_unpacker_if #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                           valid_in;
  logic                           ready_out;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_in;
  logic                           valid_out;
  logic                           ready_in;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_out;
  logic                           last_out;

  modport slave (
    input  valid_in, vector_in, ready_in,
    output ready_out, valid_out, vector_out, last_out
  );

  modport master (
    output valid_in, vector_in, ready_in,
    input  ready_out, valid_out, vector_out, last_out
  );

endinterface

// File: rtl/unpack_chunk_sel.sv
// Combinational chunk extraction: lane j takes hold[idx*L+j] for j<L, zero otherwise,
// with optional integer-to-fixed-point shift.
module unpack_chunk_sel
  import data_unpacker_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned M          = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_TYPE  = 0,
  localparam int unsigned IdxW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0][DATA_WIDTH-1:0] i_hold,
  input  len_e                         i_len,
  input  logic                         i_cast,
  input  logic [IdxW-1:0]              i_idx,
  output logic [N-1:0][DATA_WIDTH-1:0] o_chunk
);

  localparam bit CastEn = (DATA_TYPE != 0);

  int w_len;
  int w_src;

  always_comb begin
    unique case (i_len)
      LenM:    w_len = int'(M);
      Len1:    w_len = 1;
      default: w_len = int'(N);
    endcase
  end

  always_comb begin
    o_chunk = '0;
    w_src   = 0;
    for (int j = 0; j < int'(N); j++) begin
      w_src = int'(i_idx) * w_len + j;
      if (j < w_len && w_src < int'(N)) begin
        o_chunk[j] = (CastEn && i_cast) ? (i_hold[w_src[IdxW-1:0]] << (DATA_WIDTH / 2))
                                        : i_hold[w_src[IdxW-1:0]];
      end
    end
  end

endmodule

// File: rtl/data_unpacker.sv
// Splits one held N-lane vector into N/L chunks of L valid lanes, mode latched at acceptance.
// Output stage is a single register slot; ready_out looks through it when the last chunk drains.
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter int unsigned N                  = 8,
  parameter int unsigned M                  = 2,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned DATA_TYPE          = 0,
  parameter logic [7:0]  PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [7:0]  INITIAL_FIRMWARE   = 8'd0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tracing,
  input  logic [7:0]        configId,
  input  logic [7:0]        configData,
  data_unpacker_if.slave    io_bus
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [7:0]                   r_mode;
  logic [N-1:0][DATA_WIDTH-1:0] r_hold;
  len_e                         r_len;
  logic                         r_cast;
  logic                         r_buf_valid;
  logic [IdxW-1:0]              r_idx;
  logic                         r_valid_out;
  logic                         r_last_out;
  logic [N-1:0][DATA_WIDTH-1:0] r_vector_out;

  mode_dec_t                    w_dec;
  logic [IdxW-1:0]              w_last_idx;
  logic                         w_out_free;
  logic                         w_idx_last;
  logic                         w_ready;
  logic                         w_accept;
  logic [N-1:0][DATA_WIDTH-1:0] w_chunk;

  assign w_dec = decode_mode(r_mode);

  always_comb begin
    unique case (r_len)
      LenM:    w_last_idx = IdxW'(N / M - 1);
      Len1:    w_last_idx = IdxW'(N - 1);
      default: w_last_idx = '0;
    endcase
  end

  assign w_out_free = !r_valid_out || io_bus.ready_in;
  assign w_idx_last = (r_idx == w_last_idx);
  assign w_ready    = !r_buf_valid || (w_out_free && w_idx_last);
  assign w_accept   = io_bus.valid_in && tracing && w_ready;

  assign io_bus.ready_out  = w_ready;
  assign io_bus.valid_out  = r_valid_out;
  assign io_bus.last_out   = r_last_out;
  assign io_bus.vector_out = r_vector_out;

  unpack_chunk_sel #(
    .N          (N),
    .M          (M),
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_TYPE  (DATA_TYPE)
  ) u_chunk_sel (
    .i_hold  (r_hold),
    .i_len   (r_len),
    .i_cast  (r_cast),
    .i_idx   (r_idx),
    .o_chunk (w_chunk)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode <= INITIAL_FIRMWARE;
    end else if (!tracing && configId == PERSONAL_CONFIG_ID) begin
      r_mode <= configData;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold       <= '0;
      r_len        <= LenN;
      r_cast       <= 1'b0;
      r_buf_valid  <= 1'b0;
      r_idx        <= '0;
      r_valid_out  <= 1'b0;
      r_last_out   <= 1'b0;
      r_vector_out <= '0;
    end else begin
      if (w_out_free) begin
        if (r_buf_valid) begin
          r_vector_out <= w_chunk;
          r_valid_out  <= 1'b1;
          r_last_out   <= w_idx_last;
          if (w_idx_last) begin
            r_buf_valid <= 1'b0;
            r_idx       <= '0;
          end else begin
            r_idx <= r_idx + IdxW'(1);
          end
        end else begin
          r_valid_out <= 1'b0;
          r_last_out  <= 1'b0;
        end
      end
      // Acceptance overrides the end-of-vector clear so back-to-back vectors have no bubble.
      if (w_accept) begin
        r_hold      <= io_bus.vector_in;
        r_len       <= w_dec.len;
        r_cast      <= w_dec.cast;
        r_buf_valid <= !w_dec.drop;
        r_idx       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_unpacker.sv
// Self-checking bench for data_unpacker (N=8, M=2, DATA_WIDTH=32, cast enabled).
module tb_data_unpacker;
  import data_unpacker_pkg::*;

  localparam int N  = 8;
  localparam int M  = 2;
  localparam int DW = 32;
  localparam logic [7:0] ID      = 8'h05;
  localparam logic [7:0] INIT_FW = MODE_1;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct { vec_t data; logic last; } chunk_t;
  typedef struct {
    logic [7:0] mode;
    int         n_chunks;
    logic [31:0] first_l0;
    logic [31:0] first_l1;
    logic [31:0] last_l0;
  } tv_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tracing = 1'b0;
  logic [7:0] configId = 8'd0;
  logic [7:0] configData = 8'd0;

  data_unpacker_if #(.N(N), .DATA_WIDTH(DW)) bus ();

  data_unpacker #(
    .N                  (N),
    .M                  (M),
    .DATA_WIDTH         (DW),
    .DATA_TYPE          (1),
    .PERSONAL_CONFIG_ID (ID),
    .INITIAL_FIRMWARE   (INIT_FW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tracing    (tracing),
    .configId   (configId),
    .configData (configData),
    .io_bus     (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  chunk_t     exp_q[$];
  vec_t       cap_q[$];
  logic       cap_last_q[$];
  logic [7:0] model_mode = INIT_FW;
  logic       s_ready, s_valid, s_last, p_stall = 1'b0;
  vec_t       s_vec;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk_seq(input int base);
    vec_t v;
    for (int j = 0; j < N; j++) v[j] = DW'(base + j);
    return v;
  endfunction

  // Reference: a vector in mode m becomes N/L chunks of L lanes, shifted by DW/2 in cast modes.
  task automatic model_accept(input vec_t v, input logic [7:0] m);
    int     len;
    chunk_t ch;
    case (m)
      8'd0, 8'd3: len = N;
      8'd1, 8'd4: len = M;
      8'd2, 8'd5: len = 1;
      default:    len = 0;
    endcase
    for (int c = 0; len > 0 && c < N / len; c++) begin
      ch.data = '0;
      for (int j = 0; j < len; j++)
        ch.data[j] = (m >= 8'd3) ? (v[c * len + j] << (DW / 2)) : v[c * len + j];
      ch.last = (c == N / len - 1);
      exp_q.push_back(ch);
    end
  endtask

  task automatic cycle();
    chunk_t e;
    @(negedge clk);
    s_ready = bus.ready_out;
    s_valid = bus.valid_out;
    s_vec   = bus.vector_out;
    s_last  = bus.last_out;
    if (p_stall) chk_bit("stall_hold_valid", s_valid, 1'b1);
    p_stall = s_valid && !bus.ready_in;
    if (s_valid && bus.ready_in) begin
      cap_q.push_back(s_vec);
      cap_last_q.push_back(s_last);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_extra: got chunk %h expected none", s_vec);
      end else begin
        e = exp_q.pop_front();
        chk_vec("sb_data", s_vec, e.data);
        chk_bit("sb_last", s_last, e.last);
      end
    end
    if (bus.valid_in && tracing && s_ready) model_accept(bus.vector_in, model_mode);
    if (!tracing && configId == ID) model_mode = configData;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [7:0] m);
    bus.valid_in = 1'b0;
    tracing      = 1'b0;
    configId     = ID;
    configData   = m;
    cycle();
    tracing  = 1'b1;
    configId = 8'd0;
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send(input vec_t v);
    logic ok = 1'b0;
    tracing       = 1'b1;
    bus.valid_in  = 1'b1;
    bus.vector_in = v;
    for (int i = 0; i < 40 && !ok; i++) begin
      cycle();
      ok = s_ready;
    end
    bus.valid_in = 1'b0;
    if (!ok) chk_bit("accept_timeout", ok, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv_t  tbl[8];
    vec_t expv;
    int   xf;
    int   nv;

    tbl[0] = '{MODE_N,      1, 32'd1,       32'd2,       32'd1};
    tbl[1] = '{MODE_M,      4, 32'd1,       32'd2,       32'd7};
    tbl[2] = '{MODE_1,      8, 32'd1,       32'd0,       32'd8};
    tbl[3] = '{MODE_N_CAST, 1, 32'h10000,   32'h20000,   32'h10000};
    tbl[4] = '{MODE_M_CAST, 4, 32'h10000,   32'h20000,   32'h70000};
    tbl[5] = '{MODE_1_CAST, 8, 32'h10000,   32'd0,       32'h80000};
    tbl[6] = '{8'd7,        0, 32'd0,       32'd0,       32'd0};
    tbl[7] = '{8'hFF,       0, 32'd0,       32'd0,       32'd0};

    bus.valid_in  = 1'b0;
    bus.vector_in = '0;
    bus.ready_in  = 1'b0;
    #12;
    chk_bit("rst_valid", bus.valid_out, 1'b0);
    chk_bit("rst_last", bus.last_out, 1'b0);
    chk_vec("rst_vec", bus.vector_out, '0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tracing = 1'b1;

    // Reset firmware is MODE_1: eight single-lane chunks, first at t+2.
    bus.ready_in  = 1'b1;
    bus.valid_in  = 1'b1;
    bus.vector_in = mk_seq(1);
    cycle();
    chk_bit("t1_ready", s_ready, 1'b1);
    bus.valid_in = 1'b0;
    cycle();
    chk_bit("t1_gap", s_valid, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cycle();
      expv    = '0;
      expv[0] = DW'(k + 1);
      chk_bit("t1_valid", s_valid, 1'b1);
      chk_vec("t1_chunk", s_vec, expv);
      chk_bit("t1_last", s_last, k == 7);
    end
    cycle();
    chk_bit("t1_idle", s_valid, 1'b0);

    for (int t = 0; t < 8; t++) begin
      set_mode(tbl[t].mode);
      bus.ready_in = 1'b1;
      cap_q.delete();
      cap_last_q.delete();
      send(mk_seq(1));
      idle(14);
      chk_int("tbl_count", cap_q.size(), tbl[t].n_chunks);
      if (tbl[t].n_chunks > 0 && cap_q.size() == tbl[t].n_chunks) begin
        chk_int("tbl_first_l0", int'(cap_q[0][0]), int'(tbl[t].first_l0));
        chk_int("tbl_first_l1", int'(cap_q[0][1]), int'(tbl[t].first_l1));
        chk_int("tbl_last_l0", int'(cap_q[tbl[t].n_chunks - 1][0]), int'(tbl[t].last_l0));
        chk_bit("tbl_last_flag", cap_last_q[tbl[t].n_chunks - 1], 1'b1);
      end
    end

    // Back-to-back full vectors with valid_in held high.
    set_mode(MODE_N);
    idle(2);
    bus.ready_in  = 1'b1;
    bus.valid_in  = 1'b1;
    bus.vector_in = mk_seq(100);
    cycle();
    chk_bit("t3_ready_a", s_ready, 1'b1);
    bus.vector_in = mk_seq(200);
    cycle();
    chk_bit("t3_ready_b", s_ready, 1'b1);
    bus.valid_in = 1'b0;
    cycle();
    chk_vec("t3_vec_a", s_vec, mk_seq(100));
    chk_bit("t3_last_a", s_last, 1'b1);
    cycle();
    chk_vec("t3_vec_b", s_vec, mk_seq(200));
    chk_bit("t3_last_b", s_last, 1'b1);
    chk_bit("t3_valid_b", s_valid, 1'b1);
    cycle();
    chk_bit("t3_idle", s_valid, 1'b0);

    // Downstream stalls with ready_in pattern 1,0,0,1.
    set_mode(MODE_1);
    bus.ready_in = 1'b1;
    send(mk_seq(11));
    xf = 0;
    for (int p = 0; p < 60 && xf < 8; p++) begin
      bus.ready_in = (p % 4 == 0) || (p % 4 == 3);
      cycle();
      if (s_valid) begin
        expv    = '0;
        expv[0] = DW'(11 + xf);
        chk_vec("t4_chunk", s_vec, expv);
        chk_bit("t4_last", s_last, xf == 7);
        if (xf < 6) chk_bit("t4_ready_low", s_ready, 1'b0);
        if (bus.ready_in) xf++;
      end
    end
    chk_int("t4_count", xf, 8);
    bus.ready_in = 1'b1;
    idle(3);

    // Config bus: last write wins, wrong id and tracing=1 writes ignored.
    tracing    = 1'b0;
    configId   = ID;
    configData = 8'd2;
    cycle();
    configData = 8'd1;
    cycle();
    configId   = ID + 8'd1;
    configData = 8'd7;
    cycle();
    tracing    = 1'b1;
    configId   = ID;
    configData = 8'd5;
    cycle();
    configId = 8'd0;
    cap_q.delete();
    cap_last_q.delete();
    send(mk_seq(31));
    idle(12);
    chk_int("t5_cfg_count", cap_q.size(), 4);
    if (cap_q.size() > 0) begin
      chk_int("t5_cfg_l0", int'(cap_q[0][0]), 31);
      chk_int("t5_cfg_l1", int'(cap_q[0][1]), 32);
    end

    set_mode(8'd7);
    bus.valid_in  = 1'b1;
    bus.vector_in = mk_seq(41);
    cycle();
    chk_bit("t5_drop_ready", s_ready, 1'b1);
    bus.valid_in = 1'b0;
    nv = 0;
    repeat (10) begin
      cycle();
      if (s_valid) nv++;
    end
    chk_int("t5_drop_silent", nv, 0);

    // Mode rewritten while a vector drains; new vectors blocked while tracing=0.
    set_mode(MODE_M);
    cap_q.delete();
    cap_last_q.delete();
    send(mk_seq(41));
    tracing       = 1'b0;
    configId      = ID;
    configData    = MODE_N;
    bus.valid_in  = 1'b1;
    bus.vector_in = mk_seq(51);
    repeat (12) cycle();
    bus.valid_in = 1'b0;
    tracing      = 1'b1;
    configId     = 8'd0;
    chk_int("t5_mid_count", cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk_int("t5_mid_l1", int'(cap_q[3][1]), 48);
      chk_bit("t5_mid_last", cap_last_q[3], 1'b1);
    end
    cap_q.delete();
    send(mk_seq(61));
    idle(6);
    chk_int("t5_new_mode_count", cap_q.size(), 1);

    // Asynchronous reset after the third chunk.
    set_mode(MODE_1);
    send(mk_seq(71));
    xf = 0;
    for (int i = 0; i < 20 && xf < 3; i++) begin
      cycle();
      if (s_valid) xf++;
    end
    #2 reset_n = 1'b0;
    #1;
    chk_bit("t6_async_valid", bus.valid_out, 1'b0);
    chk_bit("t6_async_last", bus.last_out, 1'b0);
    chk_bit("t6_async_ready", bus.ready_out, 1'b1);
    exp_q.delete();
    model_mode = INIT_FW;
    p_stall    = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    cap_q.delete();
    send(mk_seq(81));
    idle(12);
    chk_int("t6_count", cap_q.size(), 8);
    if (cap_q.size() > 0) begin
      chk_int("t6_first_l0", int'(cap_q[0][0]), 81);
      chk_int("t6_first_l1", int'(cap_q[0][1]), 0);
    end

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      tracing      = ($urandom_range(0, 9) != 0);
      configId     = ($urandom_range(0, 1) == 1) ? ID : 8'($urandom_range(0, 255));
      configData   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(6, 255))
                                                 : 8'($urandom_range(0, 5));
      bus.valid_in = ($urandom_range(0, 9) < 6);
      for (int j = 0; j < N; j++) bus.vector_in[j] = $urandom;
      bus.ready_in = ($urandom_range(0, 9) < 7);
      cycle();
    end
    tracing      = 1'b1;
    configId     = 8'd0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    repeat (20) cycle();
    chk_int("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
